// File: rtl/m_unit.sv
// m_unit: iterative RV32M multiply/divide, one bit per cycle.
// Define M_UNIT_EARLY_OUT_EN for the unsigned a<b divide short path.
module m_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  m_con,
    input  logic        branch_output,
    output logic [31:0] out,
    output logic        m_done,
    output logic        m_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state, state_n;
    logic [3:0]  op;
    logic        a_neg, b_neg;
    logic        short_path;
    logic [31:0] short_res;
    logic [4:0]  cnt;
    logic [63:0] acc, acc_step;
    logic [31:0] mc;
    logic [31:0] result;

    // Accept-time decode
    logic        req, is_mul, is_rem;
    logic        a_sgn, b_sgn;
    logic [31:0] a_mag, b_mag;
    logic        div0, ovf, early;
    logic [31:0] short_val;

    always_comb begin
        req    = (m_con != 4'd0) && (m_con <= 4'd8);
        is_mul = (m_con >= 4'd1) && (m_con <= 4'd4);
        is_rem = (m_con == 4'd7) || (m_con == 4'd8);
        a_sgn  = (m_con == 4'd2) || (m_con == 4'd3)
              || (m_con == 4'd5) || (m_con == 4'd7);
        b_sgn  = (m_con == 4'd2) || (m_con == 4'd5)
              || (m_con == 4'd7);
        a_mag  = (a_sgn && a[31]) ? -a : a;
        b_mag  = (b_sgn && b[31]) ? -b : b;
        div0   = (b == 32'd0);
        ovf    = ((m_con == 4'd5) || (m_con == 4'd7))
              && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifdef M_UNIT_EARLY_OUT_EN
        early  = ((m_con == 4'd6) || (m_con == 4'd8)) && branch_output;
`else
        early  = 1'b0;
`endif
        if (is_rem)
            short_val = ovf ? 32'd0 : a;
        else if (div0)
            short_val = 32'hFFFF_FFFF;
        else if (ovf)
            short_val = 32'h8000_0000;
        else
            short_val = 32'd0;
    end

`ifndef M_UNIT_EARLY_OUT_EN
    logic unused_bo;
    assign unused_bo = branch_output;
`endif

    // One iteration of shift-add multiply or restoring divide
    logic [32:0] mul_sum;
    logic [32:0] div_sh, div_dif;
    logic        div_ge;
    logic [31:0] div_rem;

    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mc} : 33'd0);
        div_sh  = {acc[63:32], acc[31]};
        div_ge  = div_sh >= {1'b0, mc};
        div_dif = div_sh - {1'b0, mc};
        div_rem = div_ge ? div_dif[31:0] : div_sh[31:0];
        if (state == S_MUL)
            acc_step = {mul_sum, acc[31:1]};
        else
            acc_step = {div_rem, acc[30:0], div_ge};
    end

    logic [63:0] prod;
    logic [31:0] quo, rem;

    always_comb begin
        prod = (a_neg ^ b_neg) ? -acc_step : acc_step;
        quo  = (a_neg ^ b_neg) ? -acc_step[31:0] : acc_step[31:0];
        rem  = a_neg ? -acc_step[63:32] : acc_step[63:32];
        result = 32'd0;
        if (short_path) begin
            result = short_res;
        end else begin
            unique case (1'b1)
                (op == 4'd1):                  result = prod[31:0];
                (op >= 4'd2 && op <= 4'd4):    result = prod[63:32];
                (op == 4'd5 || op == 4'd6):    result = quo;
                default:                       result = rem;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (req) state_n = is_mul ? S_MUL : S_DIV;
            S_MUL:  if (cnt == 5'd31) state_n = S_DONE;
            S_DIV:  if (short_path || cnt == 5'd31) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op         <= 4'd0;
            a_neg      <= 1'b0;
            b_neg      <= 1'b0;
            short_path <= 1'b0;
            short_res  <= 32'd0;
            cnt        <= 5'd0;
            acc        <= 64'd0;
            mc         <= 32'd0;
            out        <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        op         <= m_con;
                        a_neg      <= a_sgn & a[31];
                        b_neg      <= b_sgn & b[31];
                        short_path <= !is_mul && (div0 || ovf || early);
                        short_res  <= short_val;
                        cnt        <= 5'd0;
                        acc        <= {32'd0, a_mag};
                        mc         <= b_mag;
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_step;
                    cnt <= cnt + 5'd1;
                    if (state_n == S_DONE)
                        out <= result;
                end
                default: ;
            endcase
        end
    end

    assign m_busy = (state == S_MUL) || (state == S_DIV);
    assign m_done = (state == S_DONE);

endmodule

// File: tb/tb_m_unit.sv
// tb_m_unit: directed scoreboard bench for m_unit.
// Expected results are queued at issue and checked at m_done.
module tb_m_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [3:0]  m_con = 4'd0;
    logic        branch_output;
    logic [31:0] out;
    logic        m_done;
    logic        m_busy;

    assign branch_output = a < b;

    always #5 clk = ~clk;

    m_unit dut (
        .clk(clk),
        .rst_n(rst_n),
        .a(a),
        .b(b),
        .m_con(m_con),
        .branch_output(branch_output),
        .out(out),
        .m_done(m_done),
        .m_busy(m_busy)
    );

`ifdef M_UNIT_EARLY_OUT_EN
    localparam int EO_CYC = 1;
`else
    localparam int EO_CYC = 32;
`endif

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] ta,
                         input logic [31:0] tb_v, input logic [31:0] res,
                         input int cyc, input string tag);
        exp_t e;
        @(negedge clk);
        a = ta;
        b = tb_v;
        m_con = op;
        e.res = res;
        e.cyc = cyc;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        a = $urandom;
        b = $urandom;
        chk({tag, "/busy_rise"}, {31'd0, m_busy}, 32'd1);
    endtask

    // m_con stays held until m_done is seen, then is dropped
    task automatic collect();
        exp_t e;
        int   n = 0;
        int   g = 0;
        logic seen = 1'b0;
        while (g < 200) begin
            @(negedge clk);
            g++;
            if (m_done) begin
                seen = 1'b1;
                break;
            end
            if (m_busy) n++;
        end
        m_con = 4'd0;
        e = sb.pop_front();
        chk({e.tag, "/done"}, {31'd0, seen}, 32'd1);
        chk({e.tag, "/out"}, out, e.res);
        chk({e.tag, "/cycles"}, 32'(n), 32'(e.cyc));
        chk({e.tag, "/busy_at_done"}, {31'd0, m_busy}, 32'd0);
        @(negedge clk);
        chk({e.tag, "/done_pulse"}, {31'd0, m_done}, 32'd0);
        chk({e.tag, "/no_reissue"}, {31'd0, m_busy}, 32'd0);
        chk({e.tag, "/out_hold"}, out, e.res);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] ta,
                       input logic [31:0] tb_v, input logic [31:0] res,
                       input int cyc, input string tag);
        issue(op, ta, tb_v, res, cyc, tag);
        collect();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst/out", out, 32'd0);
        chk("rst/busy", {31'd0, m_busy}, 32'd0);
        chk("rst/done", {31'd0, m_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(4'd1, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC, 32, "mul_a");
        run(4'd1, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFEE, 32, "mul_b");
        run(4'd1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0010, 32, "mul_c");
        run(4'd3, 32'd9, 32'd2, 32'd0, 32, "mulhsu_a");
        run(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu_b");
        run(4'd4, 32'd8, 32'd2, 32'd0, 32, "mulhu_a");
        run(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu_b");
        run(4'd2, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32, "mulh_a");
        run(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32, "mulh_b");
        run(4'd8, 32'd8, 32'd2, 32'd0, 32, "remu_a");
        run(4'd5, 32'hFFFF_FFF7, 32'd2, 32'hFFFF_FFFC, 32, "div_a");
        run(4'd7, 32'hFFFF_FFF7, 32'd2, 32'hFFFF_FFFF, 32, "rem_a");
        run(4'd5, 32'd9, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32, "div_b");
        run(4'd7, 32'd9, 32'hFFFF_FFFE, 32'd1, 32, "rem_b");
        run(4'd6, 32'd100, 32'd7, 32'd14, 32, "divu_a");
        run(4'd5, 32'd123, 32'd0, 32'hFFFF_FFFF, 1, "div_zero");
        run(4'd8, 32'd5, 32'd0, 32'd5, 1, "remu_zero");
        run(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(4'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run(4'd6, 32'd3, 32'd8, 32'd0, EO_CYC, "divu_lt");
        run(4'd8, 32'd3, 32'd8, 32'd3, EO_CYC, "remu_lt");

        // Abort a multiply mid-flight; out was 3 before reset
        @(negedge clk);
        a = 32'd5;
        b = 32'd5;
        m_con = 4'd1;
        @(posedge clk);
        #1;
        m_con = 4'd0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort/out", out, 32'd0);
        chk("abort/busy", {31'd0, m_busy}, 32'd0);
        chk("abort/done", {31'd0, m_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(4'd1, 32'd7, 32'd6, 32'd42, 32, "mul_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
